hs_link_monitor: RTL and testbench
==================================

# hs_link_monitor

Synchronous observer for one 4-phase link of the asynchronous token ring, e.g. the closing `Rreq`/`Rack` link from the last stage back to stage 0, plus that stage's `sample` error strobe.
- Resynchronises the asynchronous `req`/`ack`/`err` wires into one clock domain.
- Tracks the handshake phase and counts completed tokens and error events.
- Measures ring cycle time in clock cycles: last, minimum and maximum.
- Flags protocol violations and stalls.

It sits downstream of the ring as a pure consumer: it only receives the link wires and never drives them. It replaces testbench-only cycle-time measurement with synthesizable statistics.

## Interface
Parameters:
- `CNT_W`, 16: width of all counters and statistics.
- `TIMEOUT`, 1024: stall limit in clk cycles; must be ≥ 2 and < 2^CNT_W.
- `SYNC_STAGES`, 2: flops per synchronizer; must be ≥ 2.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `mon_req` input 1: link request, asynchronous.
- `mon_ack` input 1: link acknowledge, asynchronous.
- `mon_err` input 1: stage error/sample strobe, asynchronous.
- `clr` input 1: synchronous clear of the statistics.
- `tok_cnt` output CNT_W: number of completed handshakes.
- `err_cnt` output CNT_W: number of `mon_err` rising edges.
- `cycle_last` output CNT_W: clk cycles between the last two ack rises.
- `cycle_min` output CNT_W: smallest measured cycle.
- `cycle_max` output CNT_W: largest measured cycle.
- `cycle_valid` output 1: at least one cycle has been measured.
- `timeout` output 1: link stalled.
- `proto_err` output 1: sticky protocol violation.

## Operation
Synchronizers:
- Each async input passes through `SYNC_STAGES` flops giving `s_req`, `s_ack`, `s_err`.
- One further register holds the previous value of each, for edge and transition detection.

Phase FSM, state = {s_req, s_ack} as expected:
- IDLE(00) →REQ(10) →ACK(11) →REL(01) →IDLE.
- Only the single legal next state is accepted.
- Any other change of the sampled pair (both bits flip, or a backward step):
  - sets `proto_err`;
  - FSM adopts the observed state;
  - no count and no measurement for that sample.
- Each REL→IDLE transition increments `tok_cnt`.

Cycle measurement:
- Free counter `cyc`, saturating at all-ones, increments every clk.
- On a legal REQ→ACK (ack rise):
  - if armed: `cycle_last`←`cyc`+1, `cycle_min`←min(`cycle_min`, `cyc`+1), `cycle_max`←max, `cycle_valid`←1;
  - then `cyc`←0 and armed←1.
- The first ack rise after reset/`clr` only arms the measurement.

Error count:
- `err_cnt` increments on each `s_err` 0→1.

Stall detection:
- `idle_cnt` clears on any FSM state change and otherwise increments, saturating.
- `timeout`=1 while `idle_cnt` ≥ TIMEOUT−1 at the clock edge, i.e. exactly TIMEOUT cycles without a transition.
- `timeout` drops on the cycle after the next transition registers.

Arithmetic:
- All counters are unsigned and saturate at 2^CNT_W−1; no wrap.

`clr`:
- Zeroes `tok_cnt`, `err_cnt`, `cycle_last`, `cycle_max`, `idle_cnt`.
- Sets `cycle_min` to all-ones; clears `cycle_valid`, armed, `proto_err`, `timeout`.
- Leaves the synchronizers and the FSM state untouched.
- If `clr` coincides with an event, the clear wins and that event is dropped.

## Timing
- Reset values:
  - every counter and statistic 0, except `cycle_min` = all-ones;
  - `cycle_valid`, `timeout`, `proto_err` = 0;
  - FSM = IDLE; synchronizer flops 0.
- Reset mid-handshake: the FSM resynchronises as a legal IDLE start only if the link is at 00. Otherwise the first sample sets `proto_err`; this is accepted behaviour.
- Latency: an input edge that is stable before clk edge k is reflected in the outputs after edge k+SYNC_STAGES. Default: 2 edges later, visible from the 3rd.
- Each link phase must persist ≥ 2 clk periods to be observed; faster links give `proto_err`.
- Measured cycle error ±1 clk due to synchronizer uncertainty.

## Structure
- No package is required. If one is added, it holds only the 2-bit phase localparams IDLE/REQ/ACK/REL.
- Sub-module `sync_ff` (parameter `STAGES`, async active-high reset to 0) is instantiated 3×.
- The FSM, counters and statistics stay in `hs_link_monitor`.

## Test plan
1. Reset: hold `rst`=1 with random inputs → all outputs at reset values, `cycle_min`=16'hFFFF.
2. Steady ring: 4-phase handshake, ack rising every 10 clk, 5 tokens → `tok_cnt`=5, `cycle_last`=`cycle_min`=`cycle_max`=10, `cycle_valid`=1, `proto_err`=0.
3. Jitter: ack periods 8, 12, 9 → `cycle_min`=8, `cycle_max`=12, `cycle_last`=9.
4. Stall: freeze link in ACK, TIMEOUT=16 → `timeout` rises exactly 16 clk after the last registered transition; release → `timeout` falls, counts resume.
5. Violation: flip req and ack together in one clock → `proto_err`=1, `tok_cnt` unchanged; `clr` → `proto_err`=0, stats cleared, FSM tracks the current link state.
6. Errors and saturation: 3 `mon_err` pulses of 3 clk → `err_cnt`=3; with CNT_W=4, 20 tokens → `tok_cnt`=15 (saturated).

Source files
------------

// File: rtl/hs_link_monitor_pkg.sv
// Shared definitions for the ring link monitor.
// Phase encodings are {req, ack} as sampled on the link.
package hs_link_monitor_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b10;
  localparam logic [1:0] ACK  = 2'b11;
  localparam logic [1:0] REL  = 2'b01;

endpackage

// File: rtl/hs_link_monitor_sync_ff.sv
// Multi-flop synchronizer for one asynchronous wire.
// Resets to 0 so the link reads as IDLE after reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/hs_link_monitor.sv
// Clock-domain observer for one 4-phase ring link: phase
// tracking, token/error counts, cycle-time stats and stall flag.
module hs_link_monitor
  import hs_link_monitor_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_req,
  input  logic             mon_ack,
  input  logic             mon_err,
  input  logic             clr,
  output logic [CNT_W-1:0] tok_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] cycle_last,
  output logic [CNT_W-1:0] cycle_min,
  output logic [CNT_W-1:0] cycle_max,
  output logic             cycle_valid,
  output logic             timeout,
  output logic             proto_err
);

  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] LIM  = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == ONES) ? v : v + 1'b1;
  endfunction

  logic             s_req;
  logic             s_ack;
  logic             s_err;
  logic             p_err;
  logic [1:0]       pair;
  logic [1:0]       state;
  logic [1:0]       nxt_state;
  logic [1:0]       succ;
  logic             moved;
  logic             legal;
  logic             viol;
  logic             ack_rise;
  logic             tok_done;
  logic             err_rise;
  logic             armed;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] cyc_p1;
  logic [CNT_W-1:0] idle_cnt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .d   (mon_req),
    .q   (s_req)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk (clk),
    .rst (rst),
    .d   (mon_ack),
    .q   (s_ack)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_err (
    .clk (clk),
    .rst (rst),
    .d   (mon_err),
    .q   (s_err)
  );

  assign pair = {s_req, s_ack};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      p_err <= 1'b0;
    end else begin
      state <= nxt_state;
      p_err <= s_err;
    end
  end

  // The FSM always adopts what it sees; legality only gates events.
  always_comb begin
    succ = IDLE;
    case (state)
      IDLE:    succ = REQ;
      REQ:     succ = ACK;
      ACK:     succ = REL;
      REL:     succ = IDLE;
      default: succ = IDLE;
    endcase
    nxt_state = pair;
  end

  always_comb begin
    moved    = (pair != state);
    legal    = moved && (pair == succ);
    viol     = moved && !legal;
    ack_rise = legal && (state == REQ);
    tok_done = legal && (state == REL);
    err_rise = s_err && !p_err;
  end

  assign cyc_p1 = sat_inc(cyc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= '0;
    end else if (ack_rise && !clr) begin
      cyc <= '0;
    end else begin
      cyc <= cyc_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_cnt     <= '0;
      err_cnt     <= '0;
      cycle_last  <= '0;
      cycle_min   <= ONES;
      cycle_max   <= '0;
      cycle_valid <= 1'b0;
      armed       <= 1'b0;
      proto_err   <= 1'b0;
    end else if (clr) begin
      tok_cnt     <= '0;
      err_cnt     <= '0;
      cycle_last  <= '0;
      cycle_min   <= ONES;
      cycle_max   <= '0;
      cycle_valid <= 1'b0;
      armed       <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      if (tok_done) tok_cnt <= sat_inc(tok_cnt);
      if (err_rise) err_cnt <= sat_inc(err_cnt);
      if (viol) proto_err <= 1'b1;
      // First ack rise after reset/clear only arms the measurement.
      if (ack_rise) begin
        armed <= 1'b1;
        if (armed) begin
          cycle_last  <= cyc_p1;
          cycle_valid <= 1'b1;
          if (cyc_p1 < cycle_min) cycle_min <= cyc_p1;
          if (cyc_p1 > cycle_max) cycle_max <= cyc_p1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (clr) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      idle_cnt <= moved ? '0 : sat_inc(idle_cnt);
      timeout  <= (idle_cnt >= LIM);
    end
  end

endmodule

// File: tb/tb_hs_link_monitor.sv
// Directed bench for hs_link_monitor: reset, steady ring,
// jitter, stall, protocol violation, errors and saturation.
module tb_hs_link_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mon_req = 1'b0;
  logic        mon_ack = 1'b0;
  logic        mon_err = 1'b0;
  logic        clr = 1'b0;

  logic [15:0] tok_cnt, err_cnt;
  logic [15:0] cycle_last, cycle_min, cycle_max;
  logic        cycle_valid, timeout, proto_err;

  logic [3:0]  s_tok, s_err, s_last, s_min, s_max;
  logic        s_valid, s_to, s_perr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hs_link_monitor #(
    .CNT_W(16), .TIMEOUT(16), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .mon_req(mon_req), .mon_ack(mon_ack),
    .mon_err(mon_err), .clr(clr),
    .tok_cnt(tok_cnt), .err_cnt(err_cnt),
    .cycle_last(cycle_last), .cycle_min(cycle_min),
    .cycle_max(cycle_max), .cycle_valid(cycle_valid),
    .timeout(timeout), .proto_err(proto_err)
  );

  hs_link_monitor #(
    .CNT_W(4), .TIMEOUT(8), .SYNC_STAGES(2)
  ) u_sat (
    .clk(clk), .rst(rst),
    .mon_req(mon_req), .mon_ack(mon_ack),
    .mon_err(mon_err), .clr(clr),
    .tok_cnt(s_tok), .err_cnt(s_err),
    .cycle_last(s_last), .cycle_min(s_min),
    .cycle_max(s_max), .cycle_valid(s_valid),
    .timeout(s_to), .proto_err(s_perr)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  // One token; the next token's ack rise follows p clocks later.
  task automatic token(input int p);
    mon_req = 1'b1; step(2);
    mon_ack = 1'b1; step(2);
    mon_req = 1'b0; step(2);
    mon_ack = 1'b0; step(p - 6);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mon_req = 1'($urandom_range(0, 1));
      mon_ack = 1'($urandom_range(0, 1));
      mon_err = 1'($urandom_range(0, 1));
      step(1);
    end
    checks++;
    if ({tok_cnt, err_cnt, cycle_last, cycle_max} !== 64'd0) begin
      errors++;
      $display("FAIL reset_cnt got %h %h %h %h exp 0",
               tok_cnt, err_cnt, cycle_last, cycle_max);
    end
    checks++;
    if (cycle_min !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_min got %h exp ffff", cycle_min);
    end
    checks++;
    if ({cycle_valid, timeout, proto_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000",
               {cycle_valid, timeout, proto_err});
    end
    checks++;
    if ({s_tok, s_min, s_valid, s_perr} !== 10'b0000_1111_00) begin
      errors++;
      $display("FAIL reset_sat got %b %b %b %b exp 0000 1111 0 0",
               s_tok, s_min, s_valid, s_perr);
    end
    mon_req = 1'b0; mon_ack = 1'b0; mon_err = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);
  endtask

  task automatic test_steady();
    for (int i = 0; i < 5; i++) token(10);
    step(2);
    checks++;
    if (tok_cnt !== 16'd5) begin
      errors++;
      $display("FAIL steady_tok got %0d exp 5", tok_cnt);
    end
    checks++;
    if ({cycle_last, cycle_min, cycle_max} !== {16'd10, 16'd10, 16'd10}) begin
      errors++;
      $display("FAIL steady_cyc got %0d %0d %0d exp 10 10 10",
               cycle_last, cycle_min, cycle_max);
    end
    checks++;
    if ({cycle_valid, proto_err} !== 2'b10) begin
      errors++;
      $display("FAIL steady_flags got %b exp 10", {cycle_valid, proto_err});
    end
  endtask

  task automatic test_jitter();
    pulse_clr();
    step(1);
    checks++;
    if ({cycle_valid, cycle_min} !== {1'b0, 16'hFFFF}) begin
      errors++;
      $display("FAIL clr_stats got %b %h exp 0 ffff", cycle_valid, cycle_min);
    end
    token(8);
    token(12);
    token(9);
    token(10);
    step(2);
    checks++;
    if (cycle_min !== 16'd8) begin
      errors++;
      $display("FAIL jitter_min got %0d exp 8", cycle_min);
    end
    checks++;
    if (cycle_max !== 16'd12) begin
      errors++;
      $display("FAIL jitter_max got %0d exp 12", cycle_max);
    end
    checks++;
    if (cycle_last !== 16'd9) begin
      errors++;
      $display("FAIL jitter_last got %0d exp 9", cycle_last);
    end
    checks++;
    if (tok_cnt !== 16'd4) begin
      errors++;
      $display("FAIL jitter_tok got %0d exp 4", tok_cnt);
    end
  endtask

  task automatic test_stall();
    mon_req = 1'b1; step(2);
    mon_ack = 1'b1;
    step(18);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL stall_early got %b exp 0", timeout);
    end
    step(1);
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL stall_rise got %b exp 1", timeout);
    end
    mon_req = 1'b0;
    step(3);
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold got %b exp 1", timeout);
    end
    step(1);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL stall_fall got %b exp 0", timeout);
    end
    mon_ack = 1'b0;
    step(4);
    checks++;
    if ({tok_cnt, proto_err} !== {16'd5, 1'b0}) begin
      errors++;
      $display("FAIL stall_resume got %0d %b exp 5 0", tok_cnt, proto_err);
    end
  endtask

  task automatic test_violation();
    mon_req = 1'b1; mon_ack = 1'b1;
    step(4);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL viol_flag got %b exp 1", proto_err);
    end
    checks++;
    if (tok_cnt !== 16'd5) begin
      errors++;
      $display("FAIL viol_tok got %0d exp 5", tok_cnt);
    end
    pulse_clr();
    checks++;
    if ({proto_err, tok_cnt, cycle_valid, cycle_max} !== 34'd0) begin
      errors++;
      $display("FAIL viol_clr got %b %0d %b %0d exp 0 0 0 0",
               proto_err, tok_cnt, cycle_valid, cycle_max);
    end
    mon_req = 1'b0; step(2);
    mon_ack = 1'b0; step(4);
    checks++;
    if ({tok_cnt, proto_err} !== {16'd1, 1'b0}) begin
      errors++;
      $display("FAIL viol_track got %0d %b exp 1 0", tok_cnt, proto_err);
    end
  endtask

  task automatic test_err_sat();
    pulse_clr();
    for (int i = 0; i < 3; i++) begin
      mon_err = 1'b1; step(3);
      mon_err = 1'b0; step(3);
    end
    step(3);
    checks++;
    if (err_cnt !== 16'd3) begin
      errors++;
      $display("FAIL err_cnt got %0d exp 3", err_cnt);
    end
    checks++;
    if (s_err !== 4'd3) begin
      errors++;
      $display("FAIL err_cnt_sat got %0d exp 3", s_err);
    end
    pulse_clr();
    for (int i = 0; i < 20; i++) token(8);
    step(2);
    checks++;
    if (s_tok !== 4'd15) begin
      errors++;
      $display("FAIL sat_tok got %0d exp 15", s_tok);
    end
    checks++;
    if (tok_cnt !== 16'd20) begin
      errors++;
      $display("FAIL wide_tok got %0d exp 20", tok_cnt);
    end
    checks++;
    if ({s_last, s_min, s_max, s_valid} !== {4'd8, 4'd8, 4'd8, 1'b1}) begin
      errors++;
      $display("FAIL sat_cyc got %0d %0d %0d %b exp 8 8 8 1",
               s_last, s_min, s_max, s_valid);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_jitter();
    test_stall();
    test_violation();
    test_err_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
